// File: rtl/ram_mport_arb.sv
// ram_mport_arb
// Shared single-clock scratch RAM serving CChCnt requestor channels through a
// round-robin arbiter. One access per cycle; the granted channel may write any
// subset of bytes and/or read the word, with read-during-write returning the
// newly written bytes. Read data is registered per channel and forced to zero
// whenever that channel has no valid read pending.
//
// Ports:
//   AClkH     clock, rising edge
//   AResetN   asynchronous active-low reset
//   AClkHEn   clock enable; no state changes and no grants while low
//   AAddr     per-channel word address     (CChCnt*CAddrLen, ch0 in LSBs)
//   AMosi     per-channel write data       (CChCnt*CDataLen)
//   AWrEn     per-channel byte write mask  (CChCnt*CBytes)
//   ARdEn     per-channel read request     (CChCnt)
//   AAck      one-hot combinational grant  (CChCnt)
//   AMiso     per-channel read data, zero when not valid (CChCnt*CDataLen)
//   AMisoVld  per-channel registered read-valid (CChCnt)
module ram_mport_arb #(
    parameter int CAddrLen = 8,
    parameter int CDataLen = 16,
    parameter int CChCnt   = 2
) (
    input  logic                         AClkH,
    input  logic                         AResetN,
    input  logic                         AClkHEn,
    input  logic [CChCnt*CAddrLen-1:0]   AAddr,
    input  logic [CChCnt*CDataLen-1:0]   AMosi,
    input  logic [CChCnt*CDataLen/8-1:0] AWrEn,
    input  logic [CChCnt-1:0]            ARdEn,
    output logic [CChCnt-1:0]            AAck,
    output logic [CChCnt*CDataLen-1:0]   AMiso,
    output logic [CChCnt-1:0]            AMisoVld
);

    localparam int CBytes  = CDataLen / 8;
    localparam int CPtrLen = (CChCnt > 1) ? $clog2(CChCnt) : 1;
    localparam int CDepth  = 1 << CAddrLen;

    logic [CPtrLen-1:0]    FPtr;
    logic [CPtrLen-1:0]    nextPtr;
    logic [CPtrLen-1:0]    grantIdx;
    logic                  grantVld;
    logic [CChCnt-1:0]     chReq;
    logic [2*CChCnt-1:0]   reqRot;
    logic [CChCnt-1:0]     FRdVld;
    logic [CDataLen-1:0]   FRdData [CChCnt];
    logic [CDataLen-1:0]   mem [CDepth];

    logic [CAddrLen-1:0]   selAddr;
    logic [CDataLen-1:0]   selMosi;
    logic [CBytes-1:0]     selWrEn;
    logic                  selRdEn;
    logic [CDataLen-1:0]   selMerged;

    // A channel only counts as requesting when it reads or writes at least one
    // byte; an all-zero mask without a read is ignored entirely.
    always_comb begin
        chReq = '0;
        for (int i = 0; i < CChCnt; i++) begin
            chReq[i] = ARdEn[i] | (|AWrEn[i*CBytes +: CBytes]);
        end
    end

    // Round-robin search: rotate the request vector so that FPtr lands at bit
    // 0, take the first set bit, then map the offset back to a channel index.
    // Grants are suppressed while in reset or clock-disabled so that nothing
    // downstream (memory, pointer, read registers) can act on them.
    always_comb begin
        reqRot   = {chReq, chReq} >> FPtr;
        grantVld = 1'b0;
        grantIdx = '0;
        if (AResetN && AClkHEn) begin
            for (int k = 0; k < CChCnt; k++) begin
                if (!grantVld && reqRot[k]) begin
                    grantVld = 1'b1;
                    grantIdx = CPtrLen'((int'(FPtr) + k) % CChCnt);
                end
            end
        end
        AAck    = grantVld ? (CChCnt'(1) << grantIdx) : '0;
        nextPtr = grantVld ? CPtrLen'((int'(grantIdx) + 1) % CChCnt) : FPtr;
    end

    // Steer the granted channel's address, data and masks onto the single
    // memory port. Constant-indexed slices keep the mux free of variable
    // part-selects.
    always_comb begin
        selAddr = '0;
        selMosi = '0;
        selWrEn = '0;
        selRdEn = 1'b0;
        for (int i = 0; i < CChCnt; i++) begin
            if (grantVld && (grantIdx == CPtrLen'(i))) begin
                selAddr = AAddr[i*CAddrLen +: CAddrLen];
                selMosi = AMosi[i*CDataLen +: CDataLen];
                selWrEn = AWrEn[i*CBytes +: CBytes];
                selRdEn = ARdEn[i];
            end
        end
    end

    // Read-during-write forwarding: bytes being written this access come from
    // the write data, the rest from the stored word.
    always_comb begin
        selMerged = mem[selAddr];
        for (int b = 0; b < CBytes; b++) begin
            if (selWrEn[b]) begin
                selMerged[b*8 +: 8] = selMosi[b*8 +: 8];
            end
        end
    end

    // Memory array is intentionally outside the reset domain so its contents
    // survive a reset; grantVld already folds in reset and clock enable.
    always_ff @(posedge AClkH) begin
        if (grantVld) begin
            for (int b = 0; b < CBytes; b++) begin
                if (selWrEn[b]) begin
                    mem[selAddr][b*8 +: 8] <= selMosi[b*8 +: 8];
                end
            end
        end
    end

    // Arbiter pointer and per-channel read registers. A channel's valid flag
    // is set only on an edge that grants it a read and clears on every other
    // enabled edge, so valid lasts exactly one enabled cycle per read.
    always_ff @(posedge AClkH or negedge AResetN) begin
        if (!AResetN) begin
            FPtr   <= '0;
            FRdVld <= '0;
            for (int i = 0; i < CChCnt; i++) begin
                FRdData[i] <= '0;
            end
        end else if (AClkHEn) begin
            FPtr <= nextPtr;
            for (int i = 0; i < CChCnt; i++) begin
                if (grantVld && selRdEn && (grantIdx == CPtrLen'(i))) begin
                    FRdVld[i]  <= 1'b1;
                    FRdData[i] <= selMerged;
                end else begin
                    FRdVld[i]  <= 1'b0;
                end
            end
        end
    end

    // Output gating: read data is only visible while its valid flag is set.
    always_comb begin
        AMiso    = '0;
        AMisoVld = FRdVld;
        for (int i = 0; i < CChCnt; i++) begin
            AMiso[i*CDataLen +: CDataLen] = FRdVld[i] ? FRdData[i] : '0;
        end
    end

endmodule

// File: tb/tb_ram_mport_arb.sv
// tb_ram_mport_arb
// Directed bench for ram_mport_arb. Two instances are exercised: a 2-channel
// 8-bit-address 16-bit-data RAM and a 4-channel 10-bit-address 32-bit-data
// RAM. Expected read words are pushed onto per-channel queues as read
// requests are driven (computed from a bench memory model) and popped when
// the bench expects the corresponding read-valid.
module tb_ram_mport_arb;

    logic AClkH = 1'b0;
    logic AResetN;
    logic AClkHEn;

    always #5 AClkH = ~AClkH;

    logic [15:0]  addr2;
    logic [31:0]  mosi2;
    logic [3:0]   wrEn2;
    logic [1:0]   rdEn2;
    logic [1:0]   ack2;
    logic [31:0]  miso2;
    logic [1:0]   misoVld2;

    logic [39:0]  addr4;
    logic [127:0] mosi4;
    logic [15:0]  wrEn4;
    logic [3:0]   rdEn4;
    logic [3:0]   ack4;
    logic [127:0] miso4;
    logic [3:0]   misoVld4;

    ram_mport_arb #(.CAddrLen(8), .CDataLen(16), .CChCnt(2)) dut2 (
        .AClkH(AClkH), .AResetN(AResetN), .AClkHEn(AClkHEn),
        .AAddr(addr2), .AMosi(mosi2), .AWrEn(wrEn2), .ARdEn(rdEn2),
        .AAck(ack2), .AMiso(miso2), .AMisoVld(misoVld2)
    );

    ram_mport_arb #(.CAddrLen(10), .CDataLen(32), .CChCnt(4)) dut4 (
        .AClkH(AClkH), .AResetN(AResetN), .AClkHEn(AClkHEn),
        .AAddr(addr4), .AMosi(mosi4), .AWrEn(wrEn4), .ARdEn(rdEn4),
        .AAck(ack4), .AMiso(miso4), .AMisoVld(misoVld4)
    );

    int          assertCount = 0;
    int          failCount   = 0;
    bit          dutSel      = 1'b0;
    logic [3:0]  expVld      = '0;
    logic [31:0] lastExp [4];
    logic [31:0] expQ [4][$];
    logic [31:0] model2 [int];
    logic [31:0] model4 [int];

    function automatic int nCh();
        return dutSel ? 4 : 2;
    endfunction

    function automatic int nBytes();
        return dutSel ? 4 : 2;
    endfunction

    function automatic logic [31:0] modelRead(int a);
        if (dutSel) return model4.exists(a) ? model4[a] : 32'h0;
        return model2.exists(a) ? model2[a] : 32'h0;
    endfunction

    function automatic int getAddr(int ch);
        if (dutSel) return int'(addr4[ch*10 +: 10]);
        return int'(addr2[ch*8 +: 8]);
    endfunction

    function automatic logic [31:0] getData(int ch);
        if (dutSel) return mosi4[ch*32 +: 32];
        return {16'h0, mosi2[ch*16 +: 16]};
    endfunction

    function automatic logic [3:0] getWr(int ch);
        if (dutSel) return wrEn4[ch*4 +: 4];
        return {2'b00, wrEn2[ch*2 +: 2]};
    endfunction

    function automatic logic getRd(int ch);
        if (dutSel) return rdEn4[ch];
        return rdEn2[ch];
    endfunction

    // Single comparison point: counts every evaluation and every failure.
    task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearReq();
        addr2 = '0; mosi2 = '0; wrEn2 = '0; rdEn2 = '0;
        addr4 = '0; mosi4 = '0; wrEn4 = '0; rdEn4 = '0;
    endtask

    // Drive one channel's request; a read pushes the word the bench expects,
    // including forwarded bytes from a simultaneous write.
    task automatic driveCh(int ch, int addr, logic [31:0] data, logic [3:0] wr, logic rd);
        logic [31:0] w;
        if (dutSel) begin
            addr4[ch*10 +: 10] = 10'(addr);
            mosi4[ch*32 +: 32] = data;
            wrEn4[ch*4 +: 4]   = wr;
            rdEn4[ch]          = rd;
        end else begin
            addr2[ch*8 +: 8]   = 8'(addr);
            mosi2[ch*16 +: 16] = data[15:0];
            wrEn2[ch*2 +: 2]   = wr[1:0];
            rdEn2[ch]          = rd;
        end
        if (rd) begin
            w = modelRead(addr);
            for (int b = 0; b < nBytes(); b++) begin
                if (wr[b]) w[b*8 +: 8] = data[b*8 +: 8];
            end
            expQ[ch].push_back(w);
        end
    endtask

    // Compare read-valid and read data of every channel against the bench's
    // expectation for the current cycle.
    task automatic checkOutput();
        logic [31:0] obs;
        logic        vld;
        for (int ch = 0; ch < nCh(); ch++) begin
            vld = dutSel ? misoVld4[ch] : misoVld2[ch];
            obs = dutSel ? miso4[ch*32 +: 32] : {16'h0, miso2[ch*16 +: 16]};
            checkVal($sformatf("vld_ch%0d", ch), {31'h0, vld}, {31'h0, expVld[ch]});
            checkVal($sformatf("miso_ch%0d", ch), obs, expVld[ch] ? lastExp[ch] : 32'h0);
        end
    endtask

    // One clock cycle: check the combinational grant, let the edge happen,
    // update the model from the expected grant, then check the outputs.
    task automatic applyStimulus(logic [3:0] expAck, logic en);
        logic [3:0]  obsAck;
        logic [31:0] w;
        logic [31:0] d;
        logic [3:0]  wr;
        AClkHEn = en;
        #1;
        obsAck = dutSel ? ack4 : {2'b00, ack2};
        checkVal("ack", {28'h0, obsAck}, {28'h0, expAck});
        @(posedge AClkH);
        if (en) begin
            for (int ch = 0; ch < nCh(); ch++) begin
                if (expAck[ch]) begin
                    wr = getWr(ch);
                    d  = getData(ch);
                    w  = modelRead(getAddr(ch));
                    for (int b = 0; b < nBytes(); b++) begin
                        if (wr[b]) w[b*8 +: 8] = d[b*8 +: 8];
                    end
                    if (dutSel) model4[getAddr(ch)] = w;
                    else        model2[getAddr(ch)] = w;
                end
                if (expAck[ch] && getRd(ch)) begin
                    assertCount++;
                    assert (expQ[ch].size() != 0) else begin
                        failCount++;
                        $error("[TB] FAIL sb_underflow_ch%0d observed=0 expected=1", ch);
                    end
                    if (expQ[ch].size() != 0) lastExp[ch] = expQ[ch].pop_front();
                    expVld[ch] = 1'b1;
                end else begin
                    expVld[ch] = 1'b0;
                end
            end
        end
        @(negedge AClkH);
        checkOutput();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) lastExp[i] = '0;
        AResetN = 1'b0;
        AClkHEn = 1'b1;
        clearReq();
        @(negedge AClkH);
        @(negedge AClkH);

        // Reset state: no grant even with a request, outputs zero.
        rdEn2 = 2'b01;
        #1;
        checkVal("ack_in_reset", {30'h0, ack2}, 32'h0);
        checkOutput();
        clearReq();
        @(negedge AClkH);
        AResetN = 1'b1;

        // Contention from reset: strict alternation starting at ch0.
        driveCh(0, 'h50, 32'h1111, 4'b0011, 1'b0);
        driveCh(1, 'h51, 32'h2222, 4'b0011, 1'b0);
        applyStimulus(4'b0001, 1'b1);
        applyStimulus(4'b0010, 1'b1);
        applyStimulus(4'b0001, 1'b1);
        applyStimulus(4'b0010, 1'b1);
        clearReq();

        // Basic write then read, valid for exactly one cycle.
        driveCh(0, 'h10, 32'hA55A, 4'b0011, 1'b0);
        applyStimulus(4'b0001, 1'b1);
        clearReq();
        driveCh(0, 'h10, 32'h0, 4'b0000, 1'b1);
        applyStimulus(4'b0001, 1'b1);
        clearReq();
        applyStimulus(4'b0000, 1'b1);

        // Byte mask with read-during-write, then back-to-back reads.
        driveCh(0, 'h20, 32'h1234, 4'b0011, 1'b0);
        applyStimulus(4'b0001, 1'b1);
        driveCh(0, 'h20, 32'hFF00, 4'b0010, 1'b1);
        applyStimulus(4'b0001, 1'b1);
        clearReq();
        driveCh(0, 'h20, 32'h0, 4'b0000, 1'b1);
        applyStimulus(4'b0001, 1'b1);
        driveCh(0, 'h10, 32'h0, 4'b0000, 1'b1);
        applyStimulus(4'b0001, 1'b1);
        clearReq();

        // Zero mask and no read is not a request.
        driveCh(1, 'h20, 32'hFFFF, 4'b0000, 1'b0);
        applyStimulus(4'b0000, 1'b1);

        // Top address with full-mask write and read in one access.
        driveCh(1, 'hFF, 32'h7E81, 4'b0011, 1'b1);
        applyStimulus(4'b0010, 1'b1);
        clearReq();
        applyStimulus(4'b0000, 1'b1);

        // Clock enable: valid data held over disabled cycles, no write lands.
        driveCh(0, 'h20, 32'h0, 4'b0000, 1'b1);
        applyStimulus(4'b0001, 1'b1);
        driveCh(1, 'h20, 32'h0000, 4'b0011, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        applyStimulus(4'b0000, 1'b0);
        driveCh(1, 0, 32'h0, 4'b0000, 1'b0);
        driveCh(0, 'h20, 32'h0, 4'b0000, 1'b1);
        applyStimulus(4'b0001, 1'b1);
        clearReq();
        applyStimulus(4'b0000, 1'b1);

        // Async reset between grant and next edge.
        driveCh(0, 'h30, 32'h5555, 4'b0011, 1'b0);
        applyStimulus(4'b0001, 1'b1);
        clearReq();
        driveCh(0, 'h30, 32'h0, 4'b0000, 1'b1);
        applyStimulus(4'b0001, 1'b1);
        #2;
        AResetN = 1'b0;
        expVld  = '0;
        #1;
        checkVal("vld_async_rst", {30'h0, misoVld2}, 32'h0);
        checkVal("miso_async_rst", miso2, 32'h0);
        checkVal("ack_async_rst", {30'h0, ack2}, 32'h0);
        clearReq();
        @(negedge AClkH);
        AResetN = 1'b1;
        driveCh(0, 'h30, 32'h0, 4'b0000, 1'b1);
        driveCh(1, 'h30, 32'h0, 4'b0000, 1'b1);
        applyStimulus(4'b0001, 1'b1);
        driveCh(0, 0, 32'h0, 4'b0000, 1'b0);
        applyStimulus(4'b0010, 1'b1);
        clearReq();
        applyStimulus(4'b0000, 1'b1);

        // Four-channel instance: pointer at 2 favours ch3 over ch1.
        dutSel = 1'b1;
        expVld = '0;
        driveCh(1, 'h3FF, 32'hDEADBEEF, 4'b1111, 1'b0);
        applyStimulus(4'b0010, 1'b1);
        clearReq();
        driveCh(1, 'h3FF, 32'h0, 4'b0000, 1'b1);
        driveCh(3, 'h3FF, 32'h0, 4'b0000, 1'b1);
        applyStimulus(4'b1000, 1'b1);
        driveCh(3, 0, 32'h0, 4'b0000, 1'b0);
        applyStimulus(4'b0010, 1'b1);
        clearReq();
        applyStimulus(4'b0000, 1'b1);

        for (int ch = 0; ch < 4; ch++) begin
            checkVal($sformatf("q_empty_ch%0d", ch), 32'(expQ[ch].size()), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
